// File: rtl/ms_section_arbiter_if.sv
// Shared-channel bundle for ms_section_arbiter: requester side and downstream side.
// master = arbiter, slave = requesters plus downstream consumer.
interface ms_section_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ*DATA_W-1:0] req_val;
  logic [NUM_REQ-1:0]        req_sync;
  logic [NUM_REQ-1:0]        req_notify;
  logic [DATA_W-1:0]         out_val;
  logic                      out_notify;
  logic                      out_sync;
  logic [IDX_W-1:0]          grant_id;
  logic [1:0]                phase;
  logic [7:0]                abort_cnt;

  modport master (
    input  req_val, req_sync, out_sync,
    output req_notify, out_val, out_notify, grant_id, phase, abort_cnt
  );

  modport slave (
    output req_val, req_sync, out_sync,
    input  req_notify, out_val, out_notify, grant_id, phase, abort_cnt
  );
endinterface

// File: rtl/ms_section_arbiter.sv
// Round-robin arbiter sharing one notify/sync output channel among NUM_REQ requesters.
// Define MS_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotating pointer).
module ms_section_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  ms_section_arbiter_if.master bus
);
  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned CW      = IDX_W + 1;
  localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    SECTION_A = 2'd0,
    SECTION_B = 2'd1,
    SECTION_C = 2'd2
  } phase_e;

  phase_e              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic [NUM_REQ-1:0]  req_notify_q, req_notify_d;
  logic                out_notify_q, out_notify_d;
  logic [7:0]          abort_q, abort_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;

  logic [IDX_W-1:0]    rr_base;
  logic [IDX_W-1:0]    pick_g;
  logic [CW-1:0]       idx;
  logic                found;
  logic [DATA_W-1:0]   sel_val;

`ifdef MS_ARB_FIXED_PRIO_EN
  assign rr_base = '0;
`else
  logic [IDX_W-1:0] rr_q;

  // Pointer moves past the grantee while its grant is being acknowledged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
    end else if (state_q == SECTION_B) begin
      rr_q <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
    end
  end

  assign rr_base = rr_q;
`endif

  // First asserted requester scanning upward from rr_base with wrap-around.
  always_comb begin
    pick_g = rr_base;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_base} + CW'(i);
      if (idx >= CW'(NUM_REQ)) idx = idx - CW'(NUM_REQ);
      if (!found && bus.req_sync[idx[IDX_W-1:0]]) begin
        pick_g = idx[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_val = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_g == IDX_W'(i)) sel_val = bus.req_val[i*DATA_W +: DATA_W];
    end
  end

  // Section sequencing and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    val_d        = val_q;
    req_notify_d = '0;
    out_notify_d = out_notify_q;
    abort_d      = abort_q;
    to_cnt_d     = to_cnt_q;

    unique case (state_q)
      SECTION_A: begin
        if (|bus.req_sync) begin
          grant_d      = pick_g;
          val_d        = sel_val;
          req_notify_d = NUM_REQ'(1) << pick_g;
          state_d      = SECTION_B;
        end
      end
      SECTION_B: begin
        out_notify_d = 1'b1;
        to_cnt_d     = '0;
        state_d      = SECTION_C;
      end
      SECTION_C: begin
        if (bus.out_sync) begin
          out_notify_d = 1'b0;
          state_d      = SECTION_A;
        end else if ((TIMEOUT != 0) && (to_cnt_q == TO_W'(TO_LAST))) begin
          out_notify_d = 1'b0;
          abort_d      = (abort_q == 8'hFF) ? abort_q : abort_q + 8'd1;
          state_d      = SECTION_A;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: begin
        out_notify_d = 1'b0;
        state_d      = SECTION_A;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SECTION_A;
      grant_q      <= '0;
      val_q        <= '0;
      req_notify_q <= '0;
      out_notify_q <= 1'b0;
      abort_q      <= '0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      val_q        <= val_d;
      req_notify_q <= req_notify_d;
      out_notify_q <= out_notify_d;
      abort_q      <= abort_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign bus.req_notify = req_notify_q;
  assign bus.out_val    = val_q;
  assign bus.out_notify = out_notify_q;
  assign bus.grant_id   = grant_q;
  assign bus.phase      = state_q;
  assign bus.abort_cnt  = abort_q;

  // Grant pulse is one-hot and the offered value never moves while offered.
  a_notify_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_notify_q));
  a_val_stable:    assert property (@(posedge clk) disable iff (rst)
                                    (state_q == SECTION_C) |-> $stable(val_q));
endmodule

// File: doc/ms_section_arbiter.md
Name: ms_section_arbiter

Overview:
- Shares one master-slave output channel among NUM_REQ requesters.
- Each requester presents a value with a sync flag. The block grants one requester, captures its value, and drives it onto the shared output with a notify/sync handshake to the downstream slave.
- Arbitration is round-robin. A 3-phase section FSM sequences arbitrate, transfer and wait-for-acceptance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, value width.
- TIMEOUT, 15, max cycles in SECTION_C before abort; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- req_val  input  NUM_REQ*DATA_W  requester values; requester i occupies bits [i*DATA_W +: DATA_W]
- req_sync  input  NUM_REQ  requester i has a valid value
- req_notify  output  NUM_REQ  one-hot, 1-cycle pulse: requester i value captured
- out_val  output  DATA_W  shared output value
- out_notify  output  1  out_val valid, offered to downstream
- out_sync  input  1  downstream accepts out_val this cycle
- grant_id  output  $clog2(NUM_REQ)  index of the current or last grantee
- phase  output  2  0=SECTION_A, 1=SECTION_B, 2=SECTION_C
- abort_cnt  output  8  saturating count of timeouts

Behaviour:
- Reset (rst asynchronous, active-high; clock clk) forces:
  - phase=SECTION_A, out_val=0, out_notify=0, req_notify=0, grant_id=0;
  - rr_ptr=0, abort_cnt=0, timeout counter=0.
  - An assertion mid-transfer discards the captured value; no notify is emitted.
- SECTION_A (arbitrate):
  - Stay while req_sync==0.
  - Otherwise pick the first set bit scanning from rr_ptr upward with wrap-around. Register grant_id=g, capture out_val=req_val[g]. Next phase SECTION_B.
- SECTION_B (acknowledge):
  - req_notify[g]=1 for exactly this one cycle.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - out_notify <= 1. Next phase SECTION_C.
- SECTION_C (offer):
  - out_notify=1 and out_val held stable.
  - out_sync=1: out_notify <= 0, next phase SECTION_A.
  - TIMEOUT>0 and counter==TIMEOUT-1 without out_sync: drop the transfer (out_notify <= 0), abort_cnt++ (saturates at 255), next phase SECTION_A.
  - Timeout counter clears on entry to SECTION_C.
- Latency:
  - req_sync seen in A → req_notify 1 cycle later (B) → out_notify from the cycle after B.
  - Minimum A→A loop is 3 cycles (out_sync high on the first C cycle).
- Requester holds req_sync and req_val until req_notify. Dropping req_sync earlier withdraws the request; no error.
- req_sync changes during B/C have no effect on the current transfer.
- out_sync in SECTION_A or B is ignored.
- out_sync and timeout in the same cycle: the accept wins, abort_cnt unchanged.
- Only one requester is served per loop. A requester re-asserting immediately waits behind the other pending requesters.
- grant_id keeps its value through SECTION_A until the next grant.

Optional Feature:
- MS_ARB_FIXED_PRIO_EN defined: fixed priority, lowest asserted index wins; rr_ptr is not implemented.
- Undefined: round-robin as above.
- Phase timing, handshake and timeout are identical either way.

Test Plan:
- Reset mid-operation: req_sync=4'b0100 with req_val[2]=32'hA5A5_0002, rst asserted during SECTION_C → out_notify=0, phase=0, abort_cnt=0 immediately; no req_notify afterwards.
- Single request: req_sync=4'b0010, req_val[1]=32'h0000_00AB, out_sync=1 → cycle+1 req_notify=4'b0010, grant_id=1; cycle+2 out_notify=1, out_val=32'hAB; phase returns to 0 the next cycle.
- All requesting continuously, out_sync=1:
  - round-robin: grants 0,1,2,3,0 in order, one every 3 cycles;
  - with MS_ARB_FIXED_PRIO_EN: grant 0 every loop.
- Backpressure: out_sync held 0 for 5 cycles then 1 (TIMEOUT=15) → out_notify stays high 6 cycles, out_val stable, abort_cnt=0.
- Timeout: out_sync held 0 → out_notify drops after exactly 15 SECTION_C cycles, abort_cnt=1; 256 consecutive timeouts leave abort_cnt=255.
- Simultaneous accept and timeout: out_sync=1 on cycle 15 of SECTION_C → transfer accepted, abort_cnt unchanged.
